// File: rtl/box_probe20.sv
// box_probe20: scans a BOX_SIZE x BOX_SIZE window of the 9-bit shadow
// framebuffer through a synchronous-read port. It reports whether any pixel
// differs from the captured background colour or lies off-screen, and how many
// such pixels it found.
// Optional build macro BOX_PROBE_EARLY_EXIT_EN: stop issuing reads after the
// first hit, drain the reads still in flight, and report hit_count=1.
module box_probe20 #(
  parameter int BOX_SIZE = 20,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int RD_LAT   = 1
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic [9:0] x0,
  input  logic [8:0] y0,
  input  logic [8:0] bg_color,
  output logic [9:0] rd_x,
  output logic [8:0] rd_y,
  output logic       rd_en,
  input  logic [8:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       hit,
  output logic [8:0] hit_count
);

`ifdef BOX_PROBE_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  // The hit counter saturates at the pixel count of the box, clipped to what
  // fits in 9 bits for box sides above 22.
  localparam int         AREA  = BOX_SIZE * BOX_SIZE;
  localparam int         SAT   = (AREA > 511) ? 511 : AREA;
  localparam logic [8:0] SAT9  = SAT[8:0];
  localparam logic [4:0] LAST  = 5'(BOX_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [9:0]        x0c_q, x0c_d;
  logic [8:0]        y0c_q, y0c_d;
  logic [8:0]        bg_q, bg_d;
  logic [4:0]        xc_q, xc_d;
  logic [4:0]        yc_q, yc_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] off_q, off_d;
  logic              hit_q, hit_d;
  logic [8:0]        hit_count_q, hit_count_d;

  // Full-width coordinate sums: the low bits drive the port (wrapping), the
  // carry bits make wrapped coordinates still count as off-screen.
  logic [10:0] x_sum;
  logic [9:0]  y_sum;
  logic        off_now;
  logic        last_issue;
  logic        ret_valid;
  logic        hit_evt;

  assign x_sum      = {1'b0, x0c_q} + {6'b0, xc_q};
  assign y_sum      = {1'b0, y0c_q} + {5'b0, yc_q};
  assign off_now    = (x_sum >= 11'(SCREEN_W)) || (y_sum >= 10'(SCREEN_H));
  assign last_issue = (xc_q == LAST) && (yc_q == LAST);
  assign ret_valid  = vld_q[RD_LAT-1];
  assign hit_evt    = ret_valid && (off_q[RD_LAT-1] || (rd_data != bg_q));

  // State register; reset aborts any scan in progress.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: issue one read per cycle, then wait for returns to land.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: if (last_issue || (EARLY_EXIT && hit_evt)) state_d = S_DRAIN;
      S_DRAIN: if (vld_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: read address only driven while issuing, zero otherwise.
  always_comb begin
    rd_en = (state_q == S_ISSUE);
    rd_x  = rd_en ? x_sum[9:0] : 10'd0;
    rd_y  = rd_en ? y_sum[8:0] : 9'd0;
    busy  = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    done  = (state_q == S_DONE);
  end

  // Datapath next values: capture, scan counters, in-flight tracking, results.
  always_comb begin
    x0c_d       = x0c_q;
    y0c_d       = y0c_q;
    bg_d        = bg_q;
    xc_d        = xc_q;
    yc_d        = yc_q;
    hit_d       = hit_q;
    hit_count_d = hit_count_q;

    // Each issued read enters the tracking pipe with its off-screen verdict.
    vld_d[0] = (state_q == S_ISSUE);
    off_d[0] = off_now;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      off_d[i] = off_q[i-1];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x0c_d       = x0;
          y0c_d       = y0;
          bg_d        = bg_color;
          xc_d        = 5'd0;
          yc_d        = 5'd0;
          hit_d       = 1'b0;
          hit_count_d = 9'd0;
        end
      end
      S_ISSUE: begin
        if (xc_q == LAST) begin
          xc_d = 5'd0;
          if (yc_q != LAST) yc_d = yc_q + 5'd1;
        end else begin
          xc_d = xc_q + 5'd1;
        end
      end
      default: ;
    endcase

    // With early exit only the first hit is counted; later returns are drained.
    if (hit_evt && !(EARLY_EXIT && hit_q)) begin
      hit_d = 1'b1;
      if (hit_count_q != SAT9) hit_count_d = hit_count_q + 9'd1;
    end
  end

  // Datapath registers; reset clears results so an aborted scan reports nothing.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      x0c_q       <= '0;
      y0c_q       <= '0;
      bg_q        <= '0;
      xc_q        <= '0;
      yc_q        <= '0;
      vld_q       <= '0;
      off_q       <= '0;
      hit_q       <= 1'b0;
      hit_count_q <= '0;
    end else begin
      x0c_q       <= x0c_d;
      y0c_q       <= y0c_d;
      bg_q        <= bg_d;
      xc_q        <= xc_d;
      yc_q        <= yc_d;
      vld_q       <= vld_d;
      off_q       <= off_d;
      hit_q       <= hit_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign hit       = hit_q;
  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_box_probe20.sv
// Bench for box_probe20: a framebuffer model with one programmable colour
// pixel, a stimulus process that queues expected scan results, and a monitor
// that checks every done pulse against the queue.
module tb_box_probe20;

`ifdef BOX_PROBE_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
  localparam int RL = 2;
`else
  localparam bit EE = 1'b0;
  localparam int RL = 1;
`endif
  localparam int NB = 400;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       start    = 1'b0;
  logic [9:0] x0       = '0;
  logic [8:0] y0       = '0;
  logic [8:0] bg_color = '0;
  logic [9:0] rd_x;
  logic [8:0] rd_y;
  logic       rd_en;
  logic [8:0] rd_data;
  logic       busy, done, hit;
  logic [8:0] hit_count;

  box_probe20 #(.BOX_SIZE(20), .SCREEN_W(640), .SCREEN_H(480), .RD_LAT(RL)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .bg_color (bg_color),
    .rd_x     (rd_x),
    .rd_y     (rd_y),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .hit      (hit),
    .hit_count(hit_count)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Framebuffer: background fill plus one colour pixel, RL-cycle read pipe.
  logic [8:0] fill = '0;
  logic [8:0] pc   = '0;
  int         px   = -1;
  int         py   = -1;
  logic [8:0] fb_pipe [RL];

  function automatic logic [8:0] fb_px(input logic [9:0] xx, input logic [8:0] yy);
    if (int'(xx) == px && int'(yy) == py) return pc;
    return fill;
  endfunction

  always @(posedge CLOCK_50) begin
    fb_pipe[0] <= fb_px(rd_x, rd_y);
    for (int i = 1; i < RL; i++) fb_pipe[i] <= fb_pipe[i-1];
  end
  assign rd_data = fb_pipe[RL-1];

  typedef struct {
    int hit; int cnt; int lat; int rds; int lx; int ly; int acc;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Expected result of one scan. full = exact hit count of a complete scan,
  // k = scan index of the first hitting pixel (-1 if none).
  function automatic exp_t mk_exp(input int x, input int y, input int full, input int k);
    exp_t e;
    e.hit = (full > 0) ? 1 : 0;
    if (EE && k >= 0 && (k + RL) <= NB - 1) begin
      e.cnt = 1;
      e.rds = k + RL + 1;
      e.lat = k + 2 * RL + 2;
    end else begin
      e.cnt = (EE && full > 0) ? 1 : full;
      e.rds = NB;
      e.lat = NB + RL + 1;
    end
    e.lx  = (x + (e.rds - 1) % 20) % 1024;
    e.ly  = (y + (e.rds - 1) / 20) % 512;
    e.acc = 0;
    return e;
  endfunction

  // Drive a start request at a falling edge; leaves start high for the caller.
  task automatic start_scan(input int x, input int y, input logic [8:0] bgc,
                            input logic [8:0] fc, input int ppx, input int ppy,
                            input logic [8:0] ppc, input int full, input int k,
                            input bit push, output int acc);
    exp_t e;
    e = mk_exp(x, y, full, k);
    @(negedge CLOCK_50);
    fill = fc; px = ppx; py = ppy; pc = ppc;
    x0 = x[9:0]; y0 = y[8:0]; bg_color = bgc;
    start = 1'b1;
    acc = cyc + 1;
    e.acc = acc;
    if (push) sb.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge CLOCK_50);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no done within %0d cycles, required a done pulse", budget);
    end
  endtask

  task automatic run_scan(input int x, input int y, input logic [8:0] bgc,
                          input logic [8:0] fc, input int ppx, input int ppy,
                          input logic [8:0] ppc, input int full, input int k);
    int acc;
    start_scan(x, y, bgc, fc, ppx, ppy, ppc, full, k, 1'b1, acc);
    @(negedge CLOCK_50);
    start = 1'b0;
    wait_done(3000);
    repeat (3) @(negedge CLOCK_50);
  endtask

  // Monitor: counts reads and checks each done pulse against the scoreboard.
  int         rd_cnt = 0;
  logic [9:0] last_x = '0;
  logic [8:0] last_y = '0;
  exp_t       me;
  always @(negedge CLOCK_50) begin
    if (!resetn) begin
      rd_cnt = 0;
    end else begin
      if (rd_en) begin
        rd_cnt++;
        last_x = rd_x;
        last_y = rd_y;
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pending scan", cyc);
        end else begin
          me = sb.pop_front();
          chk("hit", 32'(hit), 32'(me.hit));
          chk("hit_count", 32'(hit_count), 32'(me.cnt));
          chk("latency", 32'(cyc - me.acc), 32'(me.lat));
          chk("read_count", 32'(rd_cnt), 32'(me.rds));
          chk("last_rd_x", 32'(last_x), 32'(me.lx));
          chk("last_rd_y", 32'(last_y), 32'(me.ly));
          $display("scan done: hit=%0d hit_count=%0d latency=%0d reads=%0d last=(%0d,%0d)",
                   hit, hit_count, cyc - me.acc, rd_cnt, last_x, last_y);
        end
        rd_cnt = 0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    // Reset state
    repeat (3) @(negedge CLOCK_50);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_rd_x", 32'(rd_x), 0);
    chk("rst_rd_y", 32'(rd_y), 0);
    chk("rst_hit", 32'(hit), 0);
    chk("rst_hit_count", 32'(hit_count), 0);
    resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    // Single colour pixel at the last scanned position
    run_scan(100, 100, 9'h000, 9'h000, 119, 119, 9'h1C0, 1, 399);
    // All background: previous hit must be cleared
    run_scan(100, 100, 9'h000, 9'h000, -1, -1, 9'h000, 0, -1);
    // Region hanging off the bottom-right corner: 300 off-screen pixels
    run_scan(630, 470, 9'h000, 9'h000, -1, -1, 9'h000, 300, 10);
    // Every pixel differs from the background: count reaches the full area
    run_scan(0, 0, 9'h155, 9'h000, -1, -1, 9'h000, 400, 0);
    // Colour pixel at offset (3,0)
    run_scan(100, 100, 9'h000, 9'h000, 103, 100, 9'h1C0, 1, 3);

    // Reset on the 50th issue cycle aborts the scan with no done pulse
    start_scan(0, 0, 9'h155, 9'h000, -1, -1, 9'h000, 400, 0, 1'b0, acc);
    @(negedge CLOCK_50);
    start = 1'b0;
    repeat (49) @(negedge CLOCK_50);
    chk("mid_busy", 32'(busy), 1);
    chk("mid_hit", 32'(hit), 1);
    resetn = 1'b0;
    @(negedge CLOCK_50);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rd_en", 32'(rd_en), 0);
    chk("abort_hit_count", 32'(hit_count), 0);
    chk("abort_done", 32'(done), 0);
    resetn = 1'b1;
    repeat (500) @(negedge CLOCK_50);

    // start pulses mid-scan are ignored; start held through DONE gives
    // exactly one more scan, accepted on the IDLE cycle after DONE
    start_scan(100, 100, 9'h000, 9'h000, -1, -1, 9'h000, 0, -1, 1'b1, acc);
    @(negedge CLOCK_50);
    start = 1'b0;
    repeat (10) @(negedge CLOCK_50);
    start = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    start = 1'b0;
    while (cyc < acc + 395) @(negedge CLOCK_50);
    start = 1'b1;
    wait_done(3000);
    @(negedge CLOCK_50);
    begin
      exp_t e2;
      e2 = mk_exp(100, 100, 0, -1);
      e2.acc = cyc + 1;
      sb.push_back(e2);
    end
    @(negedge CLOCK_50);
    start = 1'b0;
    wait_done(3000);
    repeat (30) @(negedge CLOCK_50);

    chk("pending_scans", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/box_probe20.md
Name: box_probe20

Overview:
- Reader counterpart to the 20x20 box-draw engine: scans a BOX_SIZE x BOX_SIZE region of the 9-bit shadow framebuffer and reports whether any pixel differs from the background colour.
- Tetris logic uses it for collision checks before committing a piece move.
- Sits between the game FSM and a synchronous-read port of the shadow framebuffer: it drives read coordinates and consumes the returned data.

Parameters:
- BOX_SIZE, 20, side length of the scanned square in pixels (2..31).
- SCREEN_W, 640, visible width; any x >= SCREEN_W is off-screen.
- SCREEN_H, 480, visible height; any y >= SCREEN_H is off-screen.
- RD_LAT, 1, framebuffer read latency in cycles (1..3).

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  begin a scan; sampled only in IDLE.
- x0  in  10  top-left X of the region; captured at start.
- y0  in  9  top-left Y of the region; captured at start.
- bg_color  in  9  background colour RRR_GGG_BBB; captured at start.
- rd_x  out  10  framebuffer read X.
- rd_y  out  9  framebuffer read Y.
- rd_en  out  1  read strobe; rd_data is valid RD_LAT cycles later.
- rd_data  in  9  framebuffer pixel returned for the read issued RD_LAT cycles earlier.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the result is valid.
- hit  out  1  1 if any scanned pixel is non-background or off-screen; held until the next accepted start.
- hit_count  out  9  number of such pixels (0..BOX_SIZE^2); held like hit.

Behaviour:
- Reset (resetn=0 at a clock edge): state=IDLE; rd_x=0, rd_y=0, rd_en=0, busy=0, done=0, hit=0, hit_count=0.
- Reset mid-scan aborts immediately: no done pulse, and results clear to 0.
- States:
  - IDLE: start=1 captures x0, y0, bg_color; clears xc, yc, hit, hit_count; goes to ISSUE.
  - ISSUE: rd_en=1 with rd_x=x0c+xc, rd_y=y0c+yc, each truncated to its port width (wraps).
    - xc increments every cycle.
    - At xc=BOX_SIZE-1: xc becomes 0 and yc increments.
    - At xc=yc=BOX_SIZE-1: go to DRAIN.
    - One read per cycle, no bubbles between rows.
  - DRAIN: wait until all outstanding reads have returned (RD_LAT cycles after the last issue), then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0; return to IDLE.
- Result tracking:
  - A valid shift register, RD_LAT deep, tracks each issued read.
  - A parallel RD_LAT-deep register carries an off-screen flag: computed on the pre-wrap 11-bit sum x0c+xc >= SCREEN_W, or 10-bit sum y0c+yc >= SCREEN_H.
  - When a tracked read returns: if the off-screen flag is set, or rd_data != bg_color, then hit<=1 and hit_count+=1.
  - rd_data is ignored for off-screen reads.
- Latency: with RD_LAT=1, done asserts exactly BOX_SIZE^2 + RD_LAT + 1 cycles after the start-sampling edge (402 at defaults).
- start while busy is ignored.
- start held high in DONE is not accepted that cycle; it is accepted on the following IDLE cycle.
- busy=1 in ISSUE and DRAIN only.
- hit and hit_count are stable from the done pulse until the next accepted start.
- hit_count saturates at BOX_SIZE^2; it cannot overflow 9 bits at defaults.

Optional Feature:
- Macro: BOX_PROBE_EARLY_EXIT_EN.
- Defined:
  - On the first hit detected, stop issuing reads (rd_en=0 from the next cycle) and move to DRAIN.
  - Returning in-flight reads are still drained but do not update hit_count.
  - Result: hit=1, hit_count=1 always on a hit.
  - done fires within RD_LAT+2 cycles of the first hit's data return.
- Undefined: the full scan always completes and hit_count is exact.

Test Plan:
- Framebuffer all bg_color=9'h000, start with x0=100, y0=100, RD_LAT=1 -> exactly 400 rd_en cycles; done once, 402 cycles after start; hit=0, hit_count=0.
- Single pixel (119,119)=9'h1C0, x0=y0=100 -> hit=1, hit_count=1; last read address is (119,119).
- x0=630, y0=470, all bg -> columns 640..649 and rows 480..489 are off-screen: hit=1, hit_count=400-100=300.
- Reset asserted on the 50th ISSUE cycle -> next cycle busy=0, rd_en=0, hit_count=0; no done pulse.
- start held high for 3 cycles mid-scan, then start held high through DONE -> only one extra scan, starting the cycle after DONE.
- With BOX_PROBE_EARLY_EXIT_EN and RD_LAT=2, a colour pixel at offset (3,0) -> rd_en drops within 2 cycles of that data's return; hit=1, hit_count=1; done pulses once.
